vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, the vertical equivalents in lines.
REQ-006 SHALL have port clk  input  1  single clock (one clock; no other clock domain).
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port pix_ce  input  1  pixel-clock enable; counters advance only on clk edges where pix_ce=1.
REQ-009 SHALL have port enable  input  1  run control; 0 holds the generator idle.
REQ-010 SHALL have port polarity  input  1  0 = sync active-low, 1 = sync active-high.
REQ-011 SHALL have port hsync / vsync  output  1 each  sync outputs at the selected polarity.
REQ-012 SHALL have port visible  output  1  high inside the active area.
REQ-013 SHALL have port pix_x / pix_y  output  10 each  current horizontal / vertical count.
REQ-014 SHALL have port line_start / frame_start  output  1 each  single-clk pulses.

Function
REQ-015 SHALL keep a run register that loads enable on every clk edge.
REQ-016 SHALL hold h_cnt=0 and v_cnt=0 while run=0, with visible=0, both syncs inactive and both pulses 0.
REQ-017 SHALL, when run=1 and pix_ce=1, increment h_cnt; at H_TOTAL-1 (799) wrap h_cnt to 0 and increment v_cnt; at v_cnt=V_TOTAL-1 (524) with h wrap, wrap v_cnt to 0.
REQ-018 SHALL hold all counters and outputs when pix_ce=0.
REQ-019 SHALL drive pix_x=h_cnt and pix_y=v_cnt directly from the count registers.
REQ-020 SHALL register hsync, vsync and visible from next-state counter values, so they change on the same clk edge as pix_x/pix_y.
REQ-021 SHALL assert visible when run=1, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-022 SHALL make hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
REQ-023 SHALL make vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, for whole lines.
REQ-024 SHALL apply polarity as an output XOR on the internal active-high syncs; a polarity change takes effect immediately.
REQ-025 SHALL pulse line_start for exactly one clk on the edge where h_cnt wraps to 0.
REQ-026 SHALL pulse frame_start for exactly one clk on the edge where (h_cnt,v_cnt) wraps from (799,524) to (0,0).
REQ-027 SHALL NOT pulse frame_start or line_start on the enable 0->1 start; the first frame after start begins at (0,0) without a pulse.
REQ-028 SHALL, when enable falls mid-frame, return to the idle state of REQ-016 one clk later, regardless of pix_ce.

Reset
REQ-029 SHALL, while rst_n=0, immediately force run=0, counters=0, visible=0, internal syncs inactive, pulses=0 (hsync/vsync = ~polarity).

Configuration
REQ-030 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, add output frame_cnt[7:0]; it resets to 0, increments on each frame_start and wraps from 255 to 0.
REQ-031 SHALL, without VGA_TIMING_FRAME_CNT_EN, have no frame_cnt port and no associated logic.

Structure
REQ-032 SHALL place the default timing constants, and H_TOTAL/V_TOTAL derivation helpers, in shared package vga_timing_pkg.
REQ-033 SHALL implement each axis with one sub-module, vga_axis_counter, instantiated twice: horizontal and vertical.
- vga_axis_counter is a wrap counter with increment enable, a wrap flag, and an active/sync window decode.

Verification
REQ-034 SHALL cover: reset; enable=1; pix_ce=1 constant; polarity=0 -> visible high for 640 clks per line, hsync low for clks 656..751, line_start period 800 clks.
REQ-035 SHALL cover: a full frame -> frame_start period 420000 clks, vsync low for 1600 clks starting at line 490, visible low for lines 480..524.
REQ-036 SHALL cover: pix_ce high 1 clk in 3 -> line period 2400 clks, line_start/frame_start still exactly 1 clk wide.
REQ-037 SHALL cover: polarity=1 -> hsync/vsync high only inside the windows of REQ-022/023; toggling polarity mid-line inverts the syncs immediately.
REQ-038 SHALL cover: enable dropped at (300,100) -> next clk pix_x=pix_y=0, visible=0, no pulse; re-enable -> count restarts at (0,0) with no frame_start until (799,524) wraps.
REQ-039 SHALL cover: rst_n asserted asynchronously mid-frame -> outputs reach reset values without a clk edge; with VGA_TIMING_FRAME_CNT_EN, 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the per-axis total-period helper.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Period of one axis: H_TOTAL in pixels or V_TOTAL in lines.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with increment enable, wrap flag and
// active/sync window decode of the next count value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active_nxt,
    output logic             sync_nxt
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_END);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the next value so registered outputs line up with cnt.
    assign active_nxt = (cnt_d < ACT_END);
    assign sync_nxt   = (cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI);
    assign cnt        = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator. Define VGA_TIMING_FRAME_CNT_EN to add the
// 8-bit wrapping frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       enable,
    input  logic       polarity,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic             run_d, run_q;
    logic             clr, h_inc;
    logic             h_wrap, h_act_nxt, h_sync_nxt;
    logic             v_wrap, v_act_nxt, v_sync_nxt;
    logic [CNT_W-1:0] h_cnt, v_cnt;

    logic visible_d, visible_q;
    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    // Dropping enable clears the counters on the very edge run falls, independent of pix_ce.
    assign run_d = enable;
    assign clr   = ~run_d;
    assign h_inc = run_q & pix_ce;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .inc        (h_inc),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .active_nxt (h_act_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .inc        (h_wrap),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .active_nxt (v_act_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    always_comb begin
        visible_d     = run_d & h_act_nxt & v_act_nxt;
        hsync_d       = run_d & h_sync_nxt;
        vsync_d       = run_d & v_sync_nxt;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            visible_q     <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= run_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Internal syncs are active-high; polarity=0 inverts them combinationally.
    assign hsync       = ~(hsync_q ^ polarity);
    assign vsync       = ~(vsync_q ^ polarity);
    assign visible     = visible_q;
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line behaviour, small-timing
// instance (15 x 9) for frame-level behaviour in a short run.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n, pix_ce, enable, polarity;
    logic       d_hs, d_vs, d_vis, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vis, s_ls, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] d_fc, s_fc;
    int         fcount;
`endif

    int checks = 0;
    int errors = 0;

    // Window statistics filled by measure().
    int d_vis_n, d_hs_n, d_hs_first, d_vs_n, d_ls_n, d_ls_first, d_ls_second, d_fs_n, d_xerr;
    int s_vis_n, s_vs_n, s_vs_first, s_fs_n, s_fs_first, s_fs_second;
    bit found;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_d (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .enable      (enable),
        .polarity    (polarity),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .visible     (d_vis),
        .pix_x       (d_x),
        .pix_y       (d_y),
        .line_start  (d_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt   (d_fc),
`endif
        .frame_start (d_fs)
    );

    // Small geometry: H 8/2/3/2 (total 15, hsync 10..12), V 4/1/2/2 (total 9, vsync 5..6).
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .enable      (enable),
        .polarity    (polarity),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .visible     (s_vis),
        .pix_x       (s_x),
        .pix_y       (s_y),
        .line_start  (s_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt   (s_fc),
`endif
        .frame_start (s_fs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample n negedges (k = 0 is the first sample after the start edge).
    // pix_ce is driven high after every ce_div-th sample. Sync counts are of
    // active samples at the current polarity.
    task automatic measure(input int n, input int ce_div, input int d_lim, input int s_lim);
        d_vis_n = 0; d_hs_n = 0; d_hs_first = -1; d_vs_n = 0; d_ls_n = 0;
        d_ls_first = -1; d_ls_second = -1; d_fs_n = 0; d_xerr = 0;
        s_vis_n = 0; s_vs_n = 0; s_vs_first = -1; s_fs_n = 0; s_fs_first = -1; s_fs_second = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < d_lim) begin
                if (ce_div == 1 && d_x != 10'(k)) d_xerr++;
                d_vis_n += int'(d_vis);
                if (d_hs == polarity) begin
                    d_hs_n++;
                    if (d_hs_first < 0) d_hs_first = k;
                end
            end
            if (d_vs == polarity) d_vs_n++;
            if (d_fs) d_fs_n++;
            if (d_ls) begin
                d_ls_n++;
                if (d_ls_first < 0) d_ls_first = k;
                else if (d_ls_second < 0) d_ls_second = k;
            end
            if (k < s_lim) begin
                s_vis_n += int'(s_vis);
                if (s_vs == polarity) begin
                    s_vs_n++;
                    if (s_vs_first < 0) s_vs_first = k;
                end
            end
            if (s_fs) begin
                s_fs_n++;
                if (s_fs_first < 0) s_fs_first = k;
                else if (s_fs_second < 0) s_fs_second = k;
            end
            pix_ce = (k % ce_div == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pix_ce = 1'b0; polarity = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_pix_x", d_x, 0);
        check("rst_pix_y", d_y, 0);
        check("rst_visible", d_vis, 0);
        check("rst_hsync_pol0", d_hs, 1);
        check("rst_vsync_pol0", d_vs, 1);
        check("rst_pulses", {d_ls, d_fs, s_ls, s_fs}, 0);
        polarity = 1'b1;
        #1;
        check("rst_hsync_pol1", d_hs, 0);
        polarity = 1'b0;

        // Start: pix_ce constant, active-low syncs.
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1; pix_ce = 1'b1;
        measure(1601, 1, 800, 135);
        check("line_pix_x_track", d_xerr, 0);
        check("line_visible_clks", d_vis_n, 640);
        check("line_hsync_clks", d_hs_n, 96);
        check("line_hsync_first", d_hs_first, 656);
        check("line_start_count", d_ls_n, 2);
        check("line_start_first", d_ls_first, 800);
        check("line_start_second", d_ls_second, 1600);
        check("dflt_no_frame_start", d_fs_n, 0);
        check("dflt_no_vsync", d_vs_n, 0);
        check("dflt_pix_y_line2", d_y, 2);
        check("small_visible_clks", s_vis_n, 32);
        check("small_vsync_clks", s_vs_n, 30);
        check("small_vsync_first", s_vs_first, 75);
        check("small_frame_first", s_fs_first, 135);
        check("small_frame_second", s_fs_second, 270);

        // Drop enable mid-frame (inside both sync windows), pix_ce low.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (s_x == 10'd10 && s_y == 10'd5) found = 1'b1;
        end
        check("drop_point_found", 32'(found), 1);
        enable = 1'b0; pix_ce = 1'b0;
        @(negedge clk);
        check("drop_pix_x", s_x, 0);
        check("drop_pix_y", s_y, 0);
        check("drop_visible", {s_vis, d_vis}, 0);
        check("drop_syncs_idle", {s_hs, s_vs}, 2'b11);
        check("drop_no_pulse", {s_ls, s_fs}, 0);
        check("drop_dflt_xy", {d_x, d_y}, 0);

        // Re-enable with active-high syncs.
        enable = 1'b1; pix_ce = 1'b1; polarity = 1'b1;
        measure(800, 1, 800, 135);
        check("re_pix_x_track", d_xerr, 0);
        check("re_visible_clks", d_vis_n, 640);
        check("pol1_hsync_clks", d_hs_n, 96);
        check("pol1_hsync_first", d_hs_first, 656);
        check("pol1_small_vsync_clks", s_vs_n, 30);
        check("re_small_frame_first", s_fs_first, 135);

        // Polarity toggle mid-line, inside the hsync window.
        repeat (701) @(negedge clk);
        check("tog_pix_x", d_x, 700);
        check("tog_hsync_pol1", d_hs, 1);
        polarity = 1'b0;
        #1;
        check("tog_hsync_pol0", d_hs, 0);
        check("tog_vsync_pol0", d_vs, 1);
        polarity = 1'b1;
        #1;
        check("tog_hsync_back", d_hs, 1);
        polarity = 1'b0;

        // pix_ce one clk in three, realigned through a one-clk enable drop.
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; pix_ce = 1'b1;
        measure(5000, 3, 0, 0);
        check("ce3_line_first", d_ls_first, 2398);
        check("ce3_line_period", d_ls_second - d_ls_first, 2400);
        check("ce3_line_width", d_ls_n, 2);
        check("ce3_frame_first", s_fs_first, 403);
        check("ce3_frame_period", s_fs_second - s_fs_first, 405);
        check("ce3_frame_width", s_fs_n, 12);

        // Asynchronous reset between clock edges.
        pix_ce = 1'b1;
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_xy", {d_x, d_y, s_x, s_y}, 0);
        check("arst_visible", {d_vis, s_vis}, 0);
        check("arst_syncs", {d_hs, d_vs, s_hs, s_vs}, 4'b1111);
        check("arst_pulses", {d_ls, d_fs, s_ls, s_fs}, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        check("fc_reset", s_fc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fcount = 0;
        for (int i = 0; i < 256 * 135 + 200 && fcount < 256; i++) begin
            @(negedge clk);
            if (s_fs) begin
                fcount++;
                if (fcount == 1)   check("fc_first", s_fc, 1);
                if (fcount == 255) check("fc_255", s_fc, 255);
                if (fcount == 256) check("fc_wrap", s_fc, 0);
            end
        end
        check("fc_frames_seen", fcount, 256);
        check("fc_dflt_zero", d_fc, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
